fft_out_drain: RTL and testbench

- Consumer end of the FFT core's output handshake (out_vld/out_rdy, two 32-bit lanes per beat).
- Collects one complete frame of 2^(N+1) samples into a ping-pong register buffer.
- Replays the frame to a downstream single-lane valid/ready stream, in natural or bit-reversed order.
- Sits between the FFT top and the host/DMA side, so the FFT can write frame k+1 while frame k drains.

---
 rtl/fft_out_drain.sv | 107 ++++++++++
 tb/tb_fft_out_drain.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_out_drain.sv
// FFT output drain: captures whole frames from the two-lane FFT output into a
// ping-pong register buffer and replays them as a single-lane valid/ready stream.
module fft_out_drain #(
  parameter int N      = 4,
  parameter bit BITREV = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_vld,
  output logic        s_rdy,
  input  logic [31:0] s_data0,
  input  logic [31:0] s_data1,
  output logic        m_vld,
  input  logic        m_rdy,
  output logic [31:0] m_data,
  output logic        m_last,
  output logic [15:0] frame_cnt
);

  localparam int SAMPLES = 2 ** (N + 1);
  localparam int AW      = N + 1;

  logic [31:0]   bank [2][SAMPLES];
  logic [1:0]    full;
  logic          wr_bank;
  logic          rd_bank;
  logic [N-1:0]  wr_ptr;
  logic [AW-1:0] rd_idx;
  logic [AW-1:0] rd_addr;
  logic          accept;
  logic          wr_done;
  logic          load;
  logic          rd_done;

  assign s_rdy   = !rst && !full[wr_bank];
  assign accept  = s_vld && s_rdy;
  assign wr_done = accept && (wr_ptr == {N{1'b1}});
  assign load    = full[rd_bank] && (!m_vld || m_rdy);
  assign rd_done = load && (rd_idx == {AW{1'b1}});

  always_comb begin
    rd_addr = rd_idx;
    if (BITREV) begin
      for (int i = 0; i < AW; i++) begin
        rd_addr[i] = rd_idx[AW-1-i];
      end
    end
  end

  // Sample storage carries no reset; the full flags alone decide what is valid.
  always_ff @(posedge clk) begin
    if (accept) begin
      bank[wr_bank][{wr_ptr, 1'b0}] <= s_data0;
      bank[wr_bank][{wr_ptr, 1'b1}] <= s_data1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      wr_bank <= 1'b0;
    end else if (accept) begin
      if (wr_done) begin
        wr_ptr  <= '0;
        wr_bank <= ~wr_bank;
      end else begin
        wr_ptr <= wr_ptr + 1'b1;
      end
    end
  end

  // Write completion and read release always hit different banks, so both apply.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= 2'b00;
    end else begin
      if (wr_done) full[wr_bank] <= 1'b1;
      if (rd_done) full[rd_bank] <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_data    <= '0;
      m_vld     <= 1'b0;
      m_last    <= 1'b0;
      rd_idx    <= '0;
      rd_bank   <= 1'b0;
      frame_cnt <= '0;
    end else if (load) begin
      m_data <= bank[rd_bank][rd_addr];
      m_vld  <= 1'b1;
      m_last <= (rd_idx == {AW{1'b1}});
      if (rd_done) begin
        rd_idx    <= '0;
        rd_bank   <= ~rd_bank;
        frame_cnt <= frame_cnt + 16'd1;
      end else begin
        rd_idx <= rd_idx + 1'b1;
      end
    end else if (m_vld && m_rdy) begin
      m_vld  <= 1'b0;
      m_last <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fft_out_drain.sv
// Scoreboard bench for fft_out_drain: three instances (N=2 natural, N=2 bit-reversed,
// N=4 natural) share stimulus; sel picks which one is driven and observed.
module tb_fft_out_drain;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        s_vld = 1'b0;
  logic        m_rdy = 1'b0;
  logic [31:0] s_data0 = '0;
  logic [31:0] s_data1 = '0;
  int          sel = 0;

  logic [2:0]  s_vld_k;
  logic [2:0]  s_rdy_k;
  logic [2:0]  m_vld_k;
  logic [2:0]  m_last_k;
  logic [31:0] m_data_k [3];
  logic [15:0] frame_cnt_k [3];

  logic        s_rdy_o;
  logic        m_vld_o;
  logic        m_last_o;
  logic [31:0] m_data_o;
  logic [15:0] frame_cnt_o;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_pass = 0;
  int          xfer_cnt = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  logic        prev_last = 1'b0;

  always #5 clk = ~clk;

  assign s_vld_k = {s_vld && (sel == 2), s_vld && (sel == 1), s_vld && (sel == 0)};

  always_comb begin
    s_rdy_o     = s_rdy_k[sel];
    m_vld_o     = m_vld_k[sel];
    m_last_o    = m_last_k[sel];
    m_data_o    = m_data_k[sel];
    frame_cnt_o = frame_cnt_k[sel];
  end

  fft_out_drain #(.N(2), .BITREV(1'b0)) dut_nat (
    .clk(clk), .rst(rst), .s_vld(s_vld_k[0]), .s_rdy(s_rdy_k[0]),
    .s_data0(s_data0), .s_data1(s_data1), .m_vld(m_vld_k[0]), .m_rdy(m_rdy),
    .m_data(m_data_k[0]), .m_last(m_last_k[0]), .frame_cnt(frame_cnt_k[0]));

  fft_out_drain #(.N(2), .BITREV(1'b1)) dut_rev (
    .clk(clk), .rst(rst), .s_vld(s_vld_k[1]), .s_rdy(s_rdy_k[1]),
    .s_data0(s_data0), .s_data1(s_data1), .m_vld(m_vld_k[1]), .m_rdy(m_rdy),
    .m_data(m_data_k[1]), .m_last(m_last_k[1]), .frame_cnt(frame_cnt_k[1]));

  fft_out_drain #(.N(4), .BITREV(1'b0)) dut_big (
    .clk(clk), .rst(rst), .s_vld(s_vld_k[2]), .s_rdy(s_rdy_k[2]),
    .s_data0(s_data0), .s_data1(s_data1), .m_vld(m_vld_k[2]), .m_rdy(m_rdy),
    .m_data(m_data_k[2]), .m_last(m_last_k[2]), .frame_cnt(frame_cnt_k[2]));

  function automatic logic [31:0] sample_val(int base, int j);
    int v;
    v = base + j;
    return {v[15:0], ~v[15:0]};
  endfunction

  function automatic int rev_bits(int x, int bits);
    int r;
    r = 0;
    for (int b = 0; b < bits; b++) begin
      if (x[b]) r = r | (1 << (bits - 1 - b));
    end
    return r;
  endfunction

  // Output monitor: pops the scoreboard on every transfer and checks stall stability.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        n_checks++;
        if (m_vld_o !== 1'b1 || m_data_o !== prev_data || m_last_o !== prev_last)
          $display("[TB] FAIL stall_hold: got vld=%b data=%h last=%b, need vld=1 data=%h last=%b",
                   m_vld_o, m_data_o, m_last_o, prev_data, prev_last);
        else n_pass++;
      end
      if (m_vld_o === 1'b1 && m_rdy === 1'b1) begin
        xfer_cnt++;
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("[TB] FAIL unexpected_out: got data=%h last=%b, need no output", m_data_o, m_last_o);
        end else begin
          mon_e = exp_q.pop_front();
          if (m_data_o !== mon_e.data || m_last_o !== mon_e.last)
            $display("[TB] FAIL out_sample: got data=%h last=%b, need data=%h last=%b",
                     m_data_o, m_last_o, mon_e.data, mon_e.last);
          else n_pass++;
        end
      end
      prev_stall = (m_vld_o === 1'b1) && (m_rdy === 1'b0);
      prev_data  = m_data_o;
      prev_last  = m_last_o;
    end
  end

  task automatic do_reset(input int new_sel);
    @(posedge clk);
    #1;
    rst   = 1'b1;
    s_vld = 1'b0;
    sel   = new_sel;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Pushes the expected replay order, then drives every beat until accepted.
  task automatic send_frame(input int base);
    int  beats;
    int  samples;
    int  bits;
    bit  accepted;
    exp_t e;
    beats   = (sel == 2) ? 16 : 4;
    samples = 2 * beats;
    bits    = (sel == 2) ? 5 : 3;
    for (int i = 0; i < samples; i++) begin
      e.data = sample_val(base, (sel == 1) ? rev_bits(i, bits) : i);
      e.last = (i == samples - 1);
      exp_q.push_back(e);
    end
    for (int p = 0; p < beats; p++) begin
      s_data0  = sample_val(base, 2 * p);
      s_data1  = sample_val(base, 2 * p + 1);
      s_vld    = 1'b1;
      accepted = 1'b0;
      for (int w = 0; w < 3000 && !accepted; w++) begin
        @(negedge clk);
        accepted = (s_rdy_o === 1'b1);
        @(posedge clk);
        #1;
      end
      if (!accepted) begin
        n_checks++;
        $display("[TB] FAIL send_timeout: beat %0d of base %0h got s_rdy=0, need acceptance", p, base);
        s_vld = 1'b0;
        return;
      end
    end
    s_vld = 1'b0;
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while ((exp_q.size() != 0 || m_vld_o !== 1'b0) && w < 3000) begin
      @(negedge clk);
      w++;
    end
    n_checks++;
    if (exp_q.size() != 0 || m_vld_o !== 1'b0)
      $display("[TB] FAIL drain_timeout: got %0d pending, m_vld=%b, need 0 pending, m_vld=0",
               exp_q.size(), m_vld_o);
    else n_pass++;
    @(posedge clk);
    #1;
  endtask

  // Call at a negedge; counts transfers and idle cycles once the stream has begun.
  task automatic measure_stream(input int n, output int got, output int gaps);
    got  = 0;
    gaps = 0;
    for (int w = 0; w < 1000 && got < n; w++) begin
      if (w > 0) @(negedge clk);
      if (m_vld_o === 1'b1 && m_rdy === 1'b1) got++;
      else if (got > 0) gaps++;
    end
  endtask

  task automatic test_reset();
    rst   = 1'b0;
    s_vld = 1'b1;
    m_rdy = 1'b1;
    sel   = 0;
    #1 rst = 1'b1;
    #10;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (s_rdy_k[k] !== 1'b0 || m_vld_k[k] !== 1'b0 || m_last_k[k] !== 1'b0)
        $display("[TB] FAIL reset_ctrl[%0d]: got s_rdy=%b m_vld=%b m_last=%b, need 0 0 0",
                 k, s_rdy_k[k], m_vld_k[k], m_last_k[k]);
      else n_pass++;
      n_checks++;
      if (m_data_k[k] !== 32'd0 || frame_cnt_k[k] !== 16'd0)
        $display("[TB] FAIL reset_data[%0d]: got m_data=%h frame_cnt=%0d, need 0 0",
                 k, m_data_k[k], frame_cnt_k[k]);
      else n_pass++;
    end
    s_vld = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (s_rdy_o !== 1'b1) $display("[TB] FAIL reset_release_rdy: got %b, need 1", s_rdy_o);
    else n_pass++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_natural();
    int got;
    int gaps;
    do_reset(0);
    m_rdy = 1'b1;
    send_frame(0);
    @(negedge clk);
    n_checks++;
    if (m_vld_o !== 1'b0) $display("[TB] FAIL latency_early: got m_vld=%b, need 0", m_vld_o);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (m_vld_o !== 1'b1 || m_data_o !== sample_val(0, 0))
      $display("[TB] FAIL latency_first: got vld=%b data=%h, need vld=1 data=%h",
               m_vld_o, m_data_o, sample_val(0, 0));
    else n_pass++;
    measure_stream(8, got, gaps);
    n_checks++;
    if (got !== 8 || gaps !== 0)
      $display("[TB] FAIL natural_stream: got %0d transfers %0d gaps, need 8 and 0", got, gaps);
    else n_pass++;
    wait_drain();
    n_checks++;
    if (frame_cnt_o !== 16'd1) $display("[TB] FAIL natural_frames: got %0d, need 1", frame_cnt_o);
    else n_pass++;
  endtask

  task automatic test_bitrev();
    do_reset(1);
    m_rdy = 1'b1;
    send_frame(0);
    wait_drain();
    n_checks++;
    if (frame_cnt_o !== 16'd1) $display("[TB] FAIL bitrev_frames: got %0d, need 1", frame_cnt_o);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    do_reset(0);
    m_rdy = 1'b0;
    send_frame(0);
    send_frame(8);
    @(negedge clk);
    n_checks++;
    if (s_rdy_o !== 1'b0 || m_vld_o !== 1'b1 || m_data_o !== sample_val(0, 0))
      $display("[TB] FAIL bp_full: got s_rdy=%b m_vld=%b data=%h, need 0 1 %h",
               s_rdy_o, m_vld_o, m_data_o, sample_val(0, 0));
    else n_pass++;
    fork
      send_frame(16);
      begin
        repeat (6) @(negedge clk);
        n_checks++;
        if (s_rdy_o !== 1'b0) $display("[TB] FAIL bp_hold_rdy: got %b, need 0", s_rdy_o);
        else n_pass++;
        @(posedge clk);
        #1 m_rdy = 1'b1;
      end
    join
    wait_drain();
    n_checks++;
    if (frame_cnt_o !== 16'd3) $display("[TB] FAIL bp_frames: got %0d, need 3", frame_cnt_o);
    else n_pass++;
  endtask

  task automatic test_toggle();
    int xfer0;
    do_reset(0);
    m_rdy = 1'b1;
    xfer0 = xfer_cnt;
    fork
      send_frame(0);
      begin
        repeat (40) begin
          @(posedge clk);
          #1 m_rdy = ~m_rdy;
        end
      end
    join
    m_rdy = 1'b1;
    wait_drain();
    n_checks++;
    if (xfer_cnt - xfer0 !== 8)
      $display("[TB] FAIL toggle_xfers: got %0d, need 8", xfer_cnt - xfer0);
    else n_pass++;
    n_checks++;
    if (frame_cnt_o !== 16'd1) $display("[TB] FAIL toggle_frames: got %0d, need 1", frame_cnt_o);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset(0);
    m_rdy = 1'b0;
    send_frame(32'h30);
    s_data0 = sample_val(32'h80, 0);
    s_data1 = sample_val(32'h80, 1);
    s_vld   = 1'b1;
    @(posedge clk);
    #1;
    s_data0 = sample_val(32'h80, 2);
    s_data1 = sample_val(32'h80, 3);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    exp_q.delete();
    n_checks++;
    if (s_rdy_o !== 1'b0 || m_vld_o !== 1'b0 || m_last_o !== 1'b0 || m_data_o !== 32'd0)
      $display("[TB] FAIL midreset_clear: got s_rdy=%b m_vld=%b m_last=%b data=%h, need 0 0 0 0",
               s_rdy_o, m_vld_o, m_last_o, m_data_o);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (s_rdy_o !== 1'b0 || m_vld_o !== 1'b0)
      $display("[TB] FAIL midreset_hold: got s_rdy=%b m_vld=%b, need 0 0", s_rdy_o, m_vld_o);
    else n_pass++;
    @(posedge clk);
    #1;
    s_vld = 1'b0;
    rst   = 1'b0;
    m_rdy = 1'b1;
    n_checks++;
    if (frame_cnt_o !== 16'd0) $display("[TB] FAIL midreset_cnt0: got %0d, need 0", frame_cnt_o);
    else n_pass++;
    send_frame(32'h10);
    wait_drain();
    n_checks++;
    if (frame_cnt_o !== 16'd1) $display("[TB] FAIL midreset_cnt1: got %0d, need 1", frame_cnt_o);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int got;
    int gaps;
    int w;
    do_reset(2);
    m_rdy = 1'b1;
    fork
      begin
        send_frame(32'h100);
        send_frame(32'h200);
        @(negedge clk);
        n_checks++;
        if (s_rdy_o !== 1'b0) $display("[TB] FAIL b2b_both_full: got s_rdy=%b, need 0", s_rdy_o);
        else n_pass++;
      end
      begin
        w = 0;
        while (m_vld_o !== 1'b1 && w < 200) begin
          @(negedge clk);
          w++;
        end
        measure_stream(64, got, gaps);
        n_checks++;
        if (got !== 64 || gaps !== 0)
          $display("[TB] FAIL b2b_stream: got %0d transfers %0d gaps, need 64 and 0", got, gaps);
        else n_pass++;
      end
    join
    wait_drain();
    n_checks++;
    if (s_rdy_o !== 1'b1 || frame_cnt_o !== 16'd2)
      $display("[TB] FAIL b2b_release: got s_rdy=%b frames=%0d, need 1 and 2", s_rdy_o, frame_cnt_o);
    else n_pass++;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_natural();
    test_bitrev();
    test_backpressure();
    test_toggle();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
